dual_port_memory_clr: RTL and testbench

Parametrised successor to the team's single-port synchronous test memory. Provides one read/write port (A) with byte enables and one independent read-only port (B). Replaces simulation-only initial-block zeroing with a synthesizable clear sequencer that runs after reset and on request. Used as the generic on-chip RAM model/benchmark in the memory test suite.

---
 rtl/mem_pkg.sv | 28 ++
 rtl/mem_clear_seq.sv | 54 +++++
 rtl/dual_port_memory_clr.sv | 109 ++++++++++
 tb/tb_dual_port_memory_clr.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the dual-port clearable memory.
package mem_pkg;

    localparam int unsigned RDW_OLD    = 0;
    localparam int unsigned RDW_NEW    = 1;
    localparam int unsigned MAX_DATA_W = 1024;
    localparam int unsigned MAX_BE_W   = MAX_DATA_W / 8;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    // Overlay the enabled bytes of new_w onto old_w; callers size-cast in and out.
    function automatic logic [MAX_DATA_W-1:0] be_merge(
        input logic [MAX_DATA_W-1:0] old_w,
        input logic [MAX_DATA_W-1:0] new_w,
        input logic [MAX_BE_W-1:0]   be
    );
        logic [MAX_DATA_W-1:0] r;
        r = old_w;
        for (int i = 0; i < int'(MAX_BE_W); i++) begin
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_clear_seq.sv
// Clear sweep sequencer: walks every address once after reset or on request.
module mem_clear_seq
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_we_c,
    output logic [ADDR_W-1:0] clr_adr_c
);

    clr_state_t        state, state_next;
    logic [ADDR_W-1:0] ptr, ptr_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            busy  <= (state_next == CLEAR);
        end
    end

    // The last word is written in the cycle that decides to return to IDLE.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        clr_we_c   = 1'b0;
        clr_adr_c  = ptr;
        case (state)
            CLEAR: begin
                clr_we_c = 1'b1;
                ptr_next = ptr + ADDR_W'(1);
                if (ptr == '1) begin
                    state_next = IDLE;
                    ptr_next   = '0;
                end
            end
            default: begin
                if (clr_req) begin
                    state_next = CLEAR;
                    ptr_next   = '0;
                end
            end
        endcase
    end

endmodule

// File: rtl/dual_port_memory_clr.sv
// Byte-enabled RW port A plus read-only port B over one array, with a hardware clear sweep.
module dual_port_memory_clr
    import mem_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 10,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       RDW_MODE  = 0,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_req,
    output logic                busy,
    input  logic                a_sel,
    input  logic                a_we,
    input  logic [DATA_W/8-1:0] a_be,
    input  logic [ADDR_W-1:0]   a_adr,
    input  logic [DATA_W-1:0]   a_dat_i,
    output logic [DATA_W-1:0]   a_dat_o,
    output logic                a_rvalid,
    input  logic                b_sel,
    input  logic [ADDR_W-1:0]   b_adr,
    output logic [DATA_W-1:0]   b_dat_o,
    output logic                b_rvalid
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned BE_W  = DATA_W / 8;

    if ((DATA_W % 8) != 0 || DATA_W == 0 || DATA_W > MAX_DATA_W) begin : g_bad_data_w
        $error("dual_port_memory_clr: DATA_W must be a non-zero multiple of 8 up to MAX_DATA_W");
    end
    if (RDW_MODE != RDW_OLD && RDW_MODE != RDW_NEW) begin : g_bad_rdw
        $error("dual_port_memory_clr: RDW_MODE must be 0 or 1");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we_c;
    logic [ADDR_W-1:0] clr_adr_c;
    logic              a_wr_c, a_rd_c, b_rd_c;
    logic              wr_en_c;
    logic [ADDR_W-1:0] wr_adr_c;
    logic [BE_W-1:0]   wr_be_c;
    logic [DATA_W-1:0] wr_dat_c;
    logic [DATA_W-1:0] b_word_c;

    mem_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk       (clk),
        .rst       (rst),
        .clr_req   (clr_req),
        .busy      (busy),
        .clr_we_c  (clr_we_c),
        .clr_adr_c (clr_adr_c)
    );

    assign a_wr_c = !busy && a_sel && a_we;
    assign a_rd_c = !busy && a_sel && !a_we;
    assign b_rd_c = !busy && b_sel;

    // Write port: the sweep owns it while running, otherwise port A.
    always_comb begin
        wr_en_c  = 1'b0;
        wr_adr_c = a_adr;
        wr_be_c  = a_be;
        wr_dat_c = a_dat_i;
        if (clr_we_c) begin
            wr_en_c  = 1'b1;
            wr_adr_c = clr_adr_c;
            wr_be_c  = '1;
            wr_dat_c = CLEAR_VAL;
        end else if (a_wr_c) begin
            wr_en_c  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(BE_W); i++) begin
            if (wr_en_c && wr_be_c[i]) mem[wr_adr_c][8*i +: 8] <= wr_dat_c[8*i +: 8];
        end
    end

    // Old-data collision falls out of reading before the write commits.
    always_comb begin
        b_word_c = mem[b_adr];
        if (RDW_MODE == RDW_NEW && a_wr_c && (a_adr == b_adr)) begin
            b_word_c = DATA_W'(be_merge(MAX_DATA_W'(mem[b_adr]),
                                        MAX_DATA_W'(a_dat_i),
                                        MAX_BE_W'(a_be)));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_dat_o  <= '0;
            b_dat_o  <= '0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
        end else begin
            a_rvalid <= a_rd_c;
            b_rvalid <= b_rd_c;
            if (a_rd_c) a_dat_o <= mem[a_adr];
            if (b_rd_c) b_dat_o <= b_word_c;
        end
    end

endmodule

// File: tb/tb_dual_port_memory_clr.sv
// Directed bench: old-data and new-data instances driven by the same stimulus.
module tb_dual_port_memory_clr;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr_req;
    logic        a_sel, a_we, b_sel;
    logic [3:0]  a_be;
    logic [3:0]  a_adr, b_adr;
    logic [31:0] a_dat_i;

    logic        busy0, a_rvalid0, b_rvalid0;
    logic [31:0] a_dat_o0, b_dat_o0;
    logic        busy1, a_rvalid1, b_rvalid1;
    logic [31:0] a_dat_o1, b_dat_o1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dual_port_memory_clr #(.ADDR_W(4), .DATA_W(32), .RDW_MODE(0), .CLEAR_VAL(32'h0)) u_old (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy0),
        .a_sel(a_sel), .a_we(a_we), .a_be(a_be), .a_adr(a_adr), .a_dat_i(a_dat_i),
        .a_dat_o(a_dat_o0), .a_rvalid(a_rvalid0),
        .b_sel(b_sel), .b_adr(b_adr), .b_dat_o(b_dat_o0), .b_rvalid(b_rvalid0)
    );

    dual_port_memory_clr #(.ADDR_W(4), .DATA_W(32), .RDW_MODE(1), .CLEAR_VAL(32'h0)) u_new (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy1),
        .a_sel(a_sel), .a_we(a_we), .a_be(a_be), .a_adr(a_adr), .a_dat_i(a_dat_i),
        .a_dat_o(a_dat_o1), .a_rvalid(a_rvalid1),
        .b_sel(b_sel), .b_adr(b_adr), .b_dat_o(b_dat_o1), .b_rvalid(b_rvalid1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clr_req = 1'b0; a_sel = 1'b0; a_we = 1'b0; a_be = 4'h0;
        a_adr = 4'h0; a_dat_i = 32'h0; b_sel = 1'b0; b_adr = 4'h0;
    endtask

    task automatic write_a(input logic [3:0] adr, input logic [31:0] dat, input logic [3:0] be);
        a_sel = 1'b1; a_we = 1'b1; a_adr = adr; a_dat_i = dat; a_be = be;
    endtask

    task automatic read_a(input logic [3:0] adr);
        a_sel = 1'b1; a_we = 1'b0; a_adr = adr; a_be = 4'h0;
    endtask

    // Counts cycles with busy high (bounded); optionally re-pulses clr_req mid-sweep
    // and checks that requests presented while busy produce nothing.
    task automatic count_busy(input string tag, input bit probe,
                              input logic [31:0] hold_a, input logic [31:0] hold_b);
        int n;
        n = 0;
        for (int k = 0; k < 40 && busy0 === 1'b1; k++) begin
            n++;
            if (probe) begin
                check({tag, "_busy_a_rvalid"}, 32'(a_rvalid0), 32'h0);
                check({tag, "_busy_b_rvalid"}, 32'(b_rvalid0), 32'h0);
                check({tag, "_busy_a_hold"}, a_dat_o0, hold_a);
                check({tag, "_busy_b_hold"}, b_dat_o0, hold_b);
                clr_req = (k == 5);
            end
            tick();
        end
        clr_req = 1'b0;
        check({tag, "_busy_cycles"}, 32'(n), 32'd16);
        check({tag, "_busy_new_inst"}, 32'(busy1), 32'h0);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        #1;
        check("rst_a_dat", a_dat_o0, 32'h0);
        check("rst_busy", 32'(busy0), 32'h1);
        tick();
        tick();
        check("rst_rvalid", {30'h0, a_rvalid0, b_rvalid0}, 32'h0);
        rst = 1'b0;

        count_busy("init", 1'b0, 32'h0, 32'h0);

        // Every word reads back as the clear value.
        for (int i = 0; i < 16; i++) begin
            read_a(4'(i));
            b_sel = 1'b1; b_adr = 4'(15 - i);
            tick();
            check("clr_read_a", a_dat_o0, 32'h0);
            check("clr_read_a_rvalid", 32'(a_rvalid0), 32'h1);
            check("clr_read_b", b_dat_o1, 32'h0);
        end
        idle_inputs();
        tick();
        check("rvalid_drop", {30'h0, a_rvalid0, b_rvalid0}, 32'h0);

        // Byte-enable merge.
        write_a(4'd3, 32'hDEADBEEF, 4'b1111);
        tick();
        check("wr_no_rvalid", 32'(a_rvalid0), 32'h0);
        write_a(4'd3, 32'h000000AA, 4'b0001);
        tick();
        write_a(4'd4, 32'hFFFFFFFF, 4'b0000);
        tick();
        read_a(4'd3);
        tick();
        check("be_merge_rd", a_dat_o0, 32'hDEADBEAA);
        check("be_merge_rvalid", 32'(a_rvalid0), 32'h1);
        read_a(4'd4);
        tick();
        check("be_zero_no_write", a_dat_o0, 32'h0);
        idle_inputs();
        tick();
        check("be_rvalid_pulse", 32'(a_rvalid0), 32'h0);
        check("be_hold", a_dat_o0, 32'h0);

        // Read-during-write collisions.
        write_a(4'd5, 32'h11111111, 4'b1111);
        tick();
        write_a(4'd5, 32'h22222222, 4'b1111);
        b_sel = 1'b1; b_adr = 4'd5;
        tick();
        check("rdw_old_full", b_dat_o0, 32'h11111111);
        check("rdw_new_full", b_dat_o1, 32'h22222222);
        check("rdw_b_rvalid", 32'(b_rvalid0), 32'h1);
        write_a(4'd5, 32'h33333333, 4'b0011);
        tick();
        check("rdw_old_part", b_dat_o0, 32'h22222222);
        check("rdw_new_part", b_dat_o1, 32'h22223333);
        read_a(4'd5);
        tick();
        check("same_adr_a", a_dat_o0, 32'h22223333);
        check("same_adr_b", b_dat_o0, 32'h22223333);

        // Clear request alongside a write; sweep ignores requests and a second clr_req.
        b_sel = 1'b0;
        write_a(4'd2, 32'h00000055, 4'b1111);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        read_a(4'd7);
        b_sel = 1'b1; b_adr = 4'd7;
        count_busy("req", 1'b1, 32'h22223333, 32'h22223333);
        idle_inputs();
        read_a(4'd2);
        tick();
        check("post_clr_rd2", a_dat_o0, 32'h0);
        read_a(4'd5);
        tick();
        check("post_clr_rd5", a_dat_o0, 32'h0);

        // Idle cycles hold the last read.
        write_a(4'd7, 32'h00001234, 4'b1111);
        tick();
        read_a(4'd7);
        b_sel = 1'b1; b_adr = 4'd7;
        tick();
        check("hold_rd", a_dat_o0, 32'h00001234);
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_a_dat", a_dat_o0, 32'h00001234);
            check("hold_a_rvalid", 32'(a_rvalid0), 32'h0);
        end
        check("hold_b_dat", b_dat_o0, 32'h00001234);

        // Reset in the middle of a sweep.
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("mid_busy", 32'(busy0), 32'h1);
        rst = 1'b1;
        #2;
        check("mid_rst_a", a_dat_o0, 32'h0);
        check("mid_rst_b", b_dat_o0, 32'h0);
        check("mid_rst_busy", 32'(busy0), 32'h1);
        tick();
        rst = 1'b0;
        count_busy("rst", 1'b0, 32'h0, 32'h0);
        read_a(4'd7);
        tick();
        check("post_rst_rd7", a_dat_o0, 32'h0);
        check("post_rst_rvalid", 32'(a_rvalid0), 32'h1);
        idle_inputs();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
